gb_pad_responder: RTL and testbench
===================================

Name: gb_pad_responder

Overview:
- Device-side model of the serial game-pad link: answers LATCH/PULSE from the pad-reader shift logic and shifts button state out on DATA, as a real NES-style pad does.
- Used in two places: as a bench/loopback target for the controller reader, and as an FPGA-driven virtual pad fed from a parallel button vector.
- Sits on the same three-wire link the reader drives. Input button vector uses the controller bit map: START=7, SELECT=6, B=5, A=4, DOWN=3, UP=2, LEFT=1, RIGHT=0.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on I_LATCH and I_PULSE; legal range 2..4.
- FILTER_CYCLES, 2, consecutive stable synchronized cycles required before a new level is accepted; 0 bypasses the filter.
- FILL_BIT, 0, O_DATA value driven once all 8 bits have been shifted.
- TIMEOUT_CYCLES, 4096, cycles in SHIFT with no accepted pulse before returning to IDLE; 0 disables the timeout.

Ports:
- I_CLK  in  1  system clock.
- I_RESET_L  in  1  synchronous reset, active-low.
- I_BUTTONS  in  8  pressed=1, using the bit map above.
- I_LATCH  in  1  asynchronous latch pin from the reader.
- I_PULSE  in  1  asynchronous clock pin from the reader.
- O_DATA  out  1  serial data, registered; pressed=0.
- O_BUSY  out  1  1 while in LATCHED or SHIFT.
- O_BIT_CNT  out  4  number of bits shifted since the latch fell (0..8).
- O_FRAME_DONE  out  1  one-cycle pulse when the 8th bit has been shifted.

Behaviour:
- Reset, sampled on I_CLK while I_RESET_L=0:
  - State goes to IDLE. O_DATA=1, O_BUSY=0, O_BIT_CNT=0, O_FRAME_DONE=0.
  - Synchronizer and filtered levels clear to 0; timeout counter clears.
  - Reset wins over every other event, including mid-shift.
- Input conditioning:
  - Each pin passes through SYNC_STAGES flops, then the filter.
  - The filtered level changes only after the synchronized value has differed from it for FILTER_CYCLES consecutive cycles. Any bounce restarts the count.
  - Rise and fall events are one-cycle strobes taken from the filtered level.
- Latency: a pin transition reaches O_DATA in exactly SYNC_STAGES+FILTER_CYCLES+1 cycles.
- Shift order, first bit out to last: A(4), B(5), SELECT(6), START(7), UP(2), DOWN(3), LEFT(1), RIGHT(0). Each bit is driven inverted.
- IDLE:
  - O_DATA=1.
  - Latch rise goes to LATCHED. Pulse events are ignored.
- LATCHED (parallel load, transparent):
  - Each cycle, load the shift register from I_BUTTONS and set O_DATA=~I_BUTTONS[4].
  - Pulse events are ignored; the load dominates.
  - Latch fall goes to SHIFT with O_BIT_CNT=0. The register holds the value loaded on the last LATCHED cycle.
- SHIFT:
  - Each pulse rise shifts one bit and increments O_BIT_CNT. O_DATA shows the next bit, or FILL_BIT once O_BIT_CNT=8.
  - On the increment 7->8, O_FRAME_DONE=1 for exactly one cycle.
  - Further pulses leave O_BIT_CNT saturated at 8, keep O_DATA=FILL_BIT, and raise no further O_FRAME_DONE.
  - Latch rise in SHIFT aborts the frame: go to LATCHED and clear O_BIT_CNT. No O_FRAME_DONE is raised if fewer than 8 bits were shifted.
  - Timeout: the counter restarts on every accepted pulse. Reaching TIMEOUT_CYCLES goes to IDLE with O_BIT_CNT=0 and O_DATA=1.
- Simultaneous latch-rise and pulse-rise events in the same cycle: latch wins and the pulse is dropped.
- I_BUTTONS changes during SHIFT have no effect on the current frame.
- O_BUSY=1 exactly when the state is LATCHED or SHIFT.

Test Plan:
- Defaults. After reset: O_DATA=1, O_BUSY=0, O_BIT_CNT=0.
  - I_BUTTONS=8'h11 (A, RIGHT); latch high 10 cycles then low; 8 pulses, each 10 cycles high and 10 low.
  - Required serial stream on O_DATA: 0,1,1,1,1,1,1,0, then FILL_BIT. O_FRAME_DONE pulses once.
- Latency check: latch pin rises at cycle t -> O_BUSY=1 and O_DATA=~I_BUTTONS[4] at cycle t+5.
  - Pulse rise -> O_DATA shows the next bit at +5.
- Glitches: 1-cycle and 2-cycle pulses on I_PULSE in SHIFT -> no shift, O_BIT_CNT unchanged.
  - A 3-cycle pulse -> exactly one shift.
- Abort: latch rises again after 3 pulses with I_BUTTONS=8'hFF.
  - Required: O_BIT_CNT=0, O_DATA=0, no O_FRAME_DONE.
  - A full frame afterwards then reads all zeros.
- Overrun and timeout: 10 pulses -> O_BIT_CNT stays at 8, O_FRAME_DONE raised once, bits 9-10 equal FILL_BIT.
  - With TIMEOUT_CYCLES=64, leave the line idle 64 cycles -> IDLE, O_BUSY=0, O_DATA=1.
- Simultaneous events and reset:
  - Latch and pulse pins rise in the same cycle in SHIFT -> LATCHED and O_BIT_CNT=0.
  - I_RESET_L=0 asserted mid-SHIFT -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/gb_pad_responder.sv
// Purpose : device side of the NES-style pad link; latches I_BUTTONS on LATCH and shifts them out on PULSE.
// Latency : a LATCH/PULSE pin edge reaches O_DATA after SYNC_STAGES + FILTER_CYCLES + 1 I_CLK cycles.
// Backpressure: none; the reader paces the link, and pulses beyond the 8th only hold the fill level.
module gb_pad_responder #(
   parameter int   SYNC_STAGES    = 2,
   parameter int   FILTER_CYCLES  = 2,
   parameter logic FILL_BIT       = 1'b0,
   parameter int   TIMEOUT_CYCLES = 4096
) (
   input  logic       I_CLK,
   input  logic       I_RESET_L,
   input  logic [7:0] I_BUTTONS,
   input  logic       I_LATCH,
   input  logic       I_PULSE,
   output logic       O_DATA,
   output logic       O_BUSY,
   output logic [3:0] O_BIT_CNT,
   output logic       O_FRAME_DONE
);

   // Debounce counter holds 0..FILTER_CYCLES; one flop minimum keeps the bypass case legal.
   localparam int FW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES);

   // Timeout counter holds 0..TIMEOUT_CYCLES-1; a zero timeout disables it entirely.
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LATCHED = 2'd1;
   localparam logic [1:0] ST_SHIFT   = 2'd2;

   // Channel 0 is LATCH, channel 1 is PULSE.
   logic [1:0]             pin_w;
   logic [SYNC_STAGES-1:0] sync_q [2];
   logic [FW-1:0]          fcnt_q [2];
   logic [1:0]             filt_q;
   logic [1:0]             filt_prev_q;

   logic latch_rise_w;
   logic latch_fall_w;
   logic pulse_rise_w;

   logic [1:0]    state_q, state_d;
   logic [6:0]    shreg_q, shreg_d;
   logic          data_q, data_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          done_q, done_d;
   logic [TW-1:0] tmo_q, tmo_d;

   // Buttons rearranged into wire order: bit 0 leaves first (A), bit 7 last (RIGHT).
   logic [7:0] load_w;

   assign pin_w  = {I_PULSE, I_LATCH};
   assign load_w = {I_BUTTONS[0], I_BUTTONS[1], I_BUTTONS[3], I_BUTTONS[2],
                    I_BUTTONS[7], I_BUTTONS[6], I_BUTTONS[5], I_BUTTONS[4]};

   // Synchronize both pins, then accept a new level only once it has persisted FILTER_CYCLES samples.
   always_ff @(posedge I_CLK) begin
      if (!I_RESET_L) begin
         for (int c = 0; c < 2; c++) begin
            sync_q[c] <= '0;
            fcnt_q[c] <= '0;
         end
         filt_q      <= '0;
         filt_prev_q <= '0;
      end else begin
         filt_prev_q <= filt_q;
         for (int c = 0; c < 2; c++) begin
            sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], pin_w[c]};
            if (sync_q[c][SYNC_STAGES-1] == filt_q[c]) begin
               fcnt_q[c] <= '0;
            end else if (fcnt_q[c] == FILT_LAST) begin
               filt_q[c] <= sync_q[c][SYNC_STAGES-1];
               fcnt_q[c] <= '0;
            end else begin
               fcnt_q[c] <= fcnt_q[c] + FW'(1);
            end
         end
      end
   end

   assign latch_rise_w =  filt_q[0] & ~filt_prev_q[0];
   assign latch_fall_w = ~filt_q[0] &  filt_prev_q[0];
   assign pulse_rise_w =  filt_q[1] & ~filt_prev_q[1];

   // Frame sequencing: load while latched, shift on pulses, abort on a new latch, give up on silence.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            data_d = 1'b1;
            cnt_d  = 4'd0;
            tmo_d  = '0;
            if (latch_rise_w) begin
               state_d = ST_LATCHED;
               shreg_d = load_w[7:1];
               data_d  = ~load_w[0];
            end
         end
         ST_LATCHED: begin
            // Transparent load; the last load before the fall is what gets shifted.
            shreg_d = load_w[7:1];
            data_d  = ~load_w[0];
            cnt_d   = 4'd0;
            tmo_d   = '0;
            if (latch_fall_w) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (latch_rise_w) begin
               // A new latch aborts the frame and drops any coincident pulse.
               state_d = ST_LATCHED;
               shreg_d = load_w[7:1];
               data_d  = ~load_w[0];
               cnt_d   = 4'd0;
               tmo_d   = '0;
            end else if (pulse_rise_w) begin
               tmo_d = '0;
               if (cnt_q < 4'd8) begin
                  shreg_d = {1'b0, shreg_q[6:1]};
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     data_d = FILL_BIT;
                     done_d = 1'b1;
                  end else begin
                     data_d = ~shreg_q[0];
                  end
               end else begin
                  data_d = FILL_BIT;
               end
            end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
               data_d  = 1'b1;
               tmo_d   = '0;
            end else if (TMO_EN) begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            data_d  = 1'b1;
            cnt_d   = 4'd0;
            tmo_d   = '0;
         end
      endcase
   end

   // Frame state registers; reset overrides any link activity.
   always_ff @(posedge I_CLK) begin
      if (!I_RESET_L) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         data_q  <= 1'b1;
         cnt_q   <= 4'd0;
         done_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
      end
   end

   assign O_DATA       = data_q;
   assign O_BUSY       = (state_q != ST_IDLE);
   assign O_BIT_CNT    = cnt_q;
   assign O_FRAME_DONE = done_q;

endmodule

// File: tb/tb_gb_pad_responder.sv
// Bench for gb_pad_responder: table frames, hand-written corner sequences, randomized frames vs a bit-map model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_gb_pad_responder;

   localparam logic FILL = 1'b0;

   logic       clk = 1'b0;
   logic       I_RESET_L;
   logic [7:0] I_BUTTONS;
   logic       I_LATCH;
   logic       I_PULSE;
   logic       O_DATA;
   logic       O_BUSY;
   logic [3:0] O_BIT_CNT;
   logic       O_FRAME_DONE;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int done_cnt  = 0;
   int ctx       = 0;
   int order_q [8];

   typedef struct {
      logic [7:0] btn;
      int         npulse;
      logic [7:0] stream;   // bit i = expected O_DATA after i pulses
   } vec_t;

   vec_t tbl [11];

   gb_pad_responder #(
      .SYNC_STAGES(2), .FILTER_CYCLES(2), .FILL_BIT(FILL), .TIMEOUT_CYCLES(64)
   ) dut (
      .I_CLK(clk), .I_RESET_L(I_RESET_L), .I_BUTTONS(I_BUTTONS),
      .I_LATCH(I_LATCH), .I_PULSE(I_PULSE), .O_DATA(O_DATA), .O_BUSY(O_BUSY),
      .O_BIT_CNT(O_BIT_CNT), .O_FRAME_DONE(O_FRAME_DONE)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (O_FRAME_DONE === 1'b1) done_cnt++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s (ctx %0d): got %b, expected %b", name, ctx, act, exp);
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s (ctx %0d): got %h, expected %h", name, ctx, act, exp);
   endtask

   // Expected serial level after k pulses: wire order A,B,SELECT,START,UP,DOWN,LEFT,RIGHT, active-low.
   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k >= 8) return FILL;
      return ~b[order_q[k]];
   endfunction

   task automatic do_reset();
      I_RESET_L = 1'b0;
      I_LATCH   = 1'b0;
      I_PULSE   = 1'b0;
      tick(3);
      I_RESET_L = 1'b1;
      tick(2);
   endtask

   task automatic pulse_pin(input int hi, input int lo);
      I_PULSE = 1'b1;
      tick(hi);
      I_PULSE = 1'b0;
      tick(lo);
   endtask

   task automatic latch_frame(input logic [7:0] b);
      I_BUTTONS = b;
      I_LATCH   = 1'b1;
      tick(10);
      I_LATCH   = 1'b0;
      tick(10);
   endtask

   task automatic table_frame(input vec_t v);
      logic [7:0] got;
      int         d0;
      d0  = done_cnt;
      got = 8'h00;
      latch_frame(v.btn);
      check1("frame_busy", O_BUSY, 1'b1);
      got[0] = O_DATA;
      for (int k = 1; k <= v.npulse; k++) begin
         pulse_pin(10, 10);
         if (k < 8) got[k] = O_DATA;
         else check1("fill_bit", O_DATA, FILL);
      end
      check8("stream", got, v.stream);
      check8("bit_cnt", 8'(O_BIT_CNT), (v.npulse > 8) ? 8'd8 : 8'(v.npulse));
      check8("frame_done_count", 8'(done_cnt - d0), 8'd1);
      tick(40);
      check1("busy_before_timeout", O_BUSY, 1'b1);
      tick(25);
      check1("timeout_busy", O_BUSY, 1'b0);
      check1("timeout_data", O_DATA, 1'b1);
   endtask

   initial begin
      logic [7:0] b;
      int         np;
      int         d0;

      order_q = '{4, 5, 6, 7, 2, 3, 1, 0};
      tbl[0]  = '{8'h11, 8,  8'h7E};
      tbl[1]  = '{8'h00, 8,  8'hFF};
      tbl[2]  = '{8'hFF, 8,  8'h00};
      tbl[3]  = '{8'h10, 8,  8'hFE};
      tbl[4]  = '{8'h20, 8,  8'hFD};
      tbl[5]  = '{8'h40, 8,  8'hFB};
      tbl[6]  = '{8'h80, 8,  8'hF7};
      tbl[7]  = '{8'h04, 8,  8'hEF};
      tbl[8]  = '{8'h08, 8,  8'hDF};
      tbl[9]  = '{8'h02, 10, 8'hBF};
      tbl[10] = '{8'h01, 10, 8'h7F};

      I_BUTTONS = 8'h00;
      do_reset();
      check1("reset_data", O_DATA, 1'b1);
      check1("reset_busy", O_BUSY, 1'b0);
      check8("reset_cnt", 8'(O_BIT_CNT), 8'd0);
      check1("reset_done", O_FRAME_DONE, 1'b0);

      // Table frames, each ending with a timeout back to IDLE.
      for (int i = 0; i < 11; i++) begin
         ctx = 100 + i;
         table_frame(tbl[i]);
      end

      // Latency of latch and pulse, then glitch rejection.
      ctx = 200;
      do_reset();
      I_BUTTONS = 8'h10;
      I_LATCH   = 1'b1;
      tick(5);
      check1("latch_lat_early_busy", O_BUSY, 1'b0);
      check1("latch_lat_early_data", O_DATA, 1'b1);
      tick(1);
      check1("latch_lat_busy", O_BUSY, 1'b1);
      check1("latch_lat_data", O_DATA, 1'b0);
      tick(4);
      I_LATCH = 1'b0;
      tick(10);
      I_PULSE = 1'b1;
      tick(5);
      check1("pulse_lat_early", O_DATA, 1'b0);
      tick(1);
      check1("pulse_lat_data", O_DATA, 1'b1);
      tick(4);
      I_PULSE = 1'b0;
      tick(10);
      pulse_pin(1, 10);
      check8("glitch1_cnt", 8'(O_BIT_CNT), 8'd1);
      pulse_pin(2, 10);
      check8("glitch2_cnt", 8'(O_BIT_CNT), 8'd1);
      pulse_pin(3, 10);
      check8("pulse3_cnt", 8'(O_BIT_CNT), 8'd2);

      // Abort after 3 pulses, then a clean all-pressed frame.
      ctx = 300;
      do_reset();
      latch_frame(8'hFF);
      for (int k = 0; k < 3; k++) pulse_pin(10, 10);
      check8("abort_pre_cnt", 8'(O_BIT_CNT), 8'd3);
      d0 = done_cnt;
      I_LATCH = 1'b1;
      tick(10);
      check8("abort_cnt", 8'(O_BIT_CNT), 8'd0);
      check1("abort_data", O_DATA, 1'b0);
      check1("abort_busy", O_BUSY, 1'b1);
      check8("abort_no_done", 8'(done_cnt - d0), 8'd0);
      I_LATCH = 1'b0;
      tick(10);
      begin
         logic [7:0] got;
         got = 8'hA5;
         got[0] = O_DATA;
         for (int k = 1; k < 8; k++) begin
            pulse_pin(10, 10);
            got[k] = O_DATA;
         end
         pulse_pin(10, 10);
         check8("after_abort_stream", got, 8'h00);
         check8("after_abort_done", 8'(done_cnt - d0), 8'd1);
      end

      // Latch and pulse rising together in SHIFT: latch wins.
      ctx = 400;
      do_reset();
      latch_frame(8'h10);
      pulse_pin(10, 10);
      pulse_pin(10, 10);
      check8("simul_pre_cnt", 8'(O_BIT_CNT), 8'd2);
      I_LATCH = 1'b1;
      I_PULSE = 1'b1;
      tick(10);
      check8("simul_cnt", 8'(O_BIT_CNT), 8'd0);
      check1("simul_busy", O_BUSY, 1'b1);
      I_BUTTONS = 8'h00;
      tick(2);
      check1("latched_transparent_1", O_DATA, 1'b1);
      I_BUTTONS = 8'h10;
      tick(2);
      check1("latched_transparent_0", O_DATA, 1'b0);
      I_PULSE = 1'b0;
      tick(10);
      check8("latched_ignores_pulse", 8'(O_BIT_CNT), 8'd0);
      I_LATCH = 1'b0;
      tick(10);
      pulse_pin(10, 10);
      check8("post_simul_cnt", 8'(O_BIT_CNT), 8'd1);

      // Reset in the middle of a frame.
      ctx = 500;
      I_RESET_L = 1'b0;
      I_PULSE   = 1'b1;
      tick(1);
      check1("midreset_data", O_DATA, 1'b1);
      check1("midreset_busy", O_BUSY, 1'b0);
      check8("midreset_cnt", 8'(O_BIT_CNT), 8'd0);
      check1("midreset_done", O_FRAME_DONE, 1'b0);
      I_PULSE = 1'b0;
      tick(3);
      I_RESET_L = 1'b1;
      tick(2);

      // Randomized frames against the bit-map model.
      for (int it = 0; it < 40; it++) begin
         ctx = 1000 + it;
         b  = 8'($urandom);
         np = $urandom_range(0, 10);
         d0 = done_cnt;
         I_BUTTONS = b;
         I_LATCH   = 1'b1;
         tick(10);
         check1("rnd_latched_busy", O_BUSY, 1'b1);
         check8("rnd_latched_cnt", 8'(O_BIT_CNT), 8'd0);
         check1("rnd_latched_data", O_DATA, ~b[4]);
         I_LATCH = 1'b0;
         tick(10);
         check1("rnd_bit0", O_DATA, exp_bit(b, 0));
         if ($urandom_range(0, 1) == 1) I_BUTTONS = 8'($urandom);
         for (int k = 1; k <= np; k++) begin
            if ($urandom_range(0, 3) == 0) pulse_pin($urandom_range(1, 2), 5);
            pulse_pin($urandom_range(3, 8), $urandom_range(5, 8));
            check8("rnd_cnt", 8'(O_BIT_CNT), (k > 8) ? 8'd8 : 8'(k));
            check1("rnd_data", O_DATA, exp_bit(b, k));
         end
         check8("rnd_done", 8'(done_cnt - d0), (np >= 8) ? 8'd1 : 8'd0);
         if ($urandom_range(0, 2) == 0) begin
            tick(70);
            check1("rnd_timeout_busy", O_BUSY, 1'b0);
            check1("rnd_timeout_data", O_DATA, 1'b1);
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
